// File: rtl/n64_vdemux_pg_if.sv
// Bus bundle for the N64 video demultiplexer: multiplexed input side plus
// the parallel pixel word and its strobes.
interface n64_vdemux_pg_if #(
  parameter int color_width = 7,
  parameter int n_channels  = 3,
  parameter int sync_width  = 4
);
  logic                                        nDSYNC;
  logic [color_width-1:0]                      D_i;
  logic                                        vmode;
  logic                                        n64_480i;
  logic                                        ndo_deblur;
  logic                                        n15bit_mode_i;
  logic [sync_width+n_channels*color_width-1:0] vdata_o;
  logic                                        vdata_valid_o;
  logic                                        phase_err_o;

  modport master (
    output nDSYNC, D_i, vmode, n64_480i, ndo_deblur, n15bit_mode_i,
    input  vdata_o, vdata_valid_o, phase_err_o
  );

  modport slave (
    input  nDSYNC, D_i, vmode, n64_480i, ndo_deblur, n15bit_mode_i,
    output vdata_o, vdata_valid_o, phase_err_o
  );
endinterface

// File: rtl/n64_vdemux_pg.sv
// Self-sequencing N64 video demultiplexer: collects one sync word and
// n_channels colour words per pixel (framed by nDSYNC low on the sync word),
// presents them as one parallel word with a valid strobe, flags framing
// errors, latches colour depth per frame and applies deblur blanking.
module n64_vdemux_pg #(
  parameter int color_width  = 7,
  parameter int n_channels   = 3,
  parameter int sync_width   = 4,
  parameter int reduced_lsbs = 2
) (
  input  logic           nCLK,
  input  logic           RST,
  n64_vdemux_pg_if.slave bus
);
  localparam int CH_W = n_channels * color_width;
  localparam int PH_W = $clog2(n_channels + 2);

  localparam logic [PH_W-1:0] PH_FIRST = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(n_channels);
  localparam logic [PH_W-1:0] UNLOCKED = PH_W'(n_channels + 1);

  localparam logic [color_width-1:0] KEEP_MASK =
    ~color_width'((1 << reduced_lsbs) - 1);

  logic [PH_W-1:0]        ph;
  logic                   complete;
  logic [sync_width-1:0]  sync_stage;
  logic [CH_W-1:0]        ch_stage;
  logic                   depth_full;
  logic                   nblank;
  logic [sync_width-1:0]  out_sync;
  logic [CH_W-1:0]        out_col;
  logic                   valid_q;
  logic                   err_q;

  logic [color_width-1:0] color_in;
  logic                   vsync_fall;
  logic                   csync_rise;
  logic                   nblank_next;

  // Depth-adjusted colour word, sync edge detection and next deblur state.
  always_comb begin
    color_in    = depth_full ? bus.D_i : (bus.D_i & KEEP_MASK);
    vsync_fall  = sync_stage[3] & ~bus.D_i[3];
    csync_rise  = ~sync_stage[0] & bus.D_i[0];
    nblank_next = ~nblank;
    if (bus.n64_480i || bus.ndo_deblur) begin
      nblank_next = 1'b1;
    end else if (csync_rise) begin
      nblank_next = bus.vmode;
    end
  end

  // Phase sequencing, staging, depth/deblur latches and output transfer.
  // ph parks at UNLOCKED both when waiting for lock and when a complete
  // pixel is held; 'complete' tells the two apart, so a late sync or a
  // reset only needs to clear that flag to drop the pixel.
  always_ff @(negedge nCLK or posedge RST) begin
    if (RST) begin
      ph         <= UNLOCKED;
      complete   <= 1'b0;
      sync_stage <= '1;
      ch_stage   <= '0;
      depth_full <= 1'b1;
      nblank     <= 1'b1;
      out_sync   <= '1;
      out_col    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (!bus.nDSYNC) begin
        sync_stage <= bus.D_i[sync_width-1:0];
        ph         <= PH_FIRST;
        complete   <= 1'b0;
        nblank     <= nblank_next;
        if (vsync_fall) begin
          depth_full <= bus.n15bit_mode_i;
        end
        if (ph == UNLOCKED) begin
          if (complete) begin
            out_sync <= sync_stage;
            if (nblank) begin
              out_col <= ch_stage;
            end
            valid_q <= 1'b1;
          end
        end else begin
          err_q <= 1'b1;
        end
      end else if (ph != UNLOCKED) begin
        for (int unsigned i = 0; i < n_channels; i++) begin
          if (ph == PH_W'(i + 1)) begin
            ch_stage[(n_channels - 1 - i) * color_width +: color_width] <= color_in;
          end
        end
        ph <= ph + PH_W'(1);
        if (ph == PH_LAST) begin
          complete <= 1'b1;
        end
      end else if (complete) begin
        err_q    <= 1'b1;
        complete <= 1'b0;
      end
    end
  end

  assign bus.vdata_o       = {out_sync, out_col};
  assign bus.vdata_valid_o = valid_q;
  assign bus.phase_err_o   = err_q;
endmodule

// File: doc/n64_vdemux_pg.md
# n64_vdemux_pg

Parametrised, self-sequencing successor to the N64 video demultiplexer. Captures the time-multiplexed N64 video bus (one sync word followed by `n_channels` colour words per pixel, framed by nDSYNC) and presents one parallel pixel word with a one-cycle valid strobe. Adds an internal phase counter with framing-error detection, a per-frame colour-depth latch and deblur blanking. Sits directly behind the input pins, ahead of the scaler/encoder chain.

## Interface
- color_width, 7: bits per colour channel and width of D_i.
- n_channels, 3: colour words per pixel, 1..7.
- sync_width, 4: sync bits taken from D_i[sync_width-1:0], at least 4, at most color_width; bit 3 is nVSYNC, bit 0 is nCSYNC.
- reduced_lsbs, 2: LSBs forced to zero in reduced-depth mode, less than color_width.

Ports:
- nCLK  in  1  pixel-bus clock; all registers update on its falling edge.
- RST  in  1  asynchronous, active-high reset.
- nDSYNC  in  1  low marks the sync word of a pixel.
- D_i  in  color_width  multiplexed bus.
- vmode  in  1  blanking phase after nCSYNC rising edge (deblur).
- n64_480i  in  1  interlaced; disables deblur blanking.
- ndo_deblur  in  1  deblur off.
- n15bit_mode_i  in  1  1 = full depth, 0 = reduced; sampled per frame.
- vdata_o  out  sync_width+n_channels*color_width  {sync, ch0 … ch(n-1)}; sync in the MSBs, ch(n-1) in the LSBs.
- vdata_valid_o  out  1  one-cycle strobe: vdata_o updated.
- phase_err_o  out  1  one-cycle strobe: framing error.

## Operation
- Phase counter `ph` is 0..n_channels+1. The value n_channels+1 is UNLOCKED. Reset puts it in UNLOCKED.
- nDSYNC low:
  - Capture D_i[sync_width-1:0] into the sync stage and set ph to 1.
  - If ph equals n_channels+1 (a complete pixel is held), transfer stage to output (see below) and pulse vdata_valid_o.
  - If ph is 1..n_channels (early sync, pixel incomplete), pulse phase_err_o, do not transfer, and discard the partial colour.
  - If ph is UNLOCKED after reset or an error, no error and no transfer.
- nDSYNC high with ph k in 1..n_channels: store D_i into channel k-1 and increment ph.
  - Full depth: store D_i unchanged.
  - Reduced depth: store {D_i[color_width-1:reduced_lsbs], zeros}.
  - At k = n_channels, ph becomes n_channels+1 (complete).
- nDSYNC high with ph already complete (late sync): hold ph and ignore data. The first such cycle pulses phase_err_o and clears the complete flag. The pixel is then dropped; the next nDSYNC low behaves as after UNLOCKED.
- Depth latch: on a nDSYNC-low edge where the stored nVSYNC is 1 and D_i[3] is 0, load n15bit_mode_i. Reset value is 1.
- Deblur `nblank`, updated on each nDSYNC-low edge:
  - Forced to 1 when n64_480i or ndo_deblur is set.
  - Else on an nCSYNC rising edge (stored bit 0 is 0, D_i[0] is 1): set to vmode.
  - Else toggle.
  - Reset value is 1.
- Transfer:
  - The sync field always updates.
  - Colour fields update only if nblank is 1; otherwise they hold the previous pixel.
  - vdata_valid_o pulses regardless of nblank.
- Simultaneous nVSYNC falling edge and transfer: the outgoing pixel keeps its already-decoded depth. The new depth applies from the next captured colour word.

## Timing
- Reset values:
  - vdata_o: sync bits all 1, colour bits 0.
  - vdata_valid_o 0, phase_err_o 0.
  - ph UNLOCKED, nblank 1, depth latch 1.
- Latency: sync captured at edge T, colours at T+1..T+n. vdata_o and vdata_valid_o change at the next nDSYNC-low edge T+n+1, one edge after the last colour word.
- Strobes are high exactly one nCLK period.
- Steady-state throughput is one pixel per n_channels+1 cycles.
- RST asserted mid-pixel clears everything immediately. After release, the first nDSYNC low only locks the counter, and the first valid output appears one full pixel later.

## Test plan
- Nominal, defaults: sync 4'hF, colours 7'h55, 7'h2A, 7'h7F, then nDSYNC low → vdata_o = {4'hF, 7'h55, 7'h2A, 7'h7F} and one-cycle vdata_valid_o; no phase_err_o.
- Reduced depth: with n15bit_mode_i = 0, drive sync 4'hF then 4'h7 (nVSYNC falling edge), then colour 7'h7F → stored colour 7'h7C. Also check the previous pixel still shows full depth.
- Early sync: nDSYNC low after only two colour words → phase_err_o pulses once, no valid pulse, next nominal pixel outputs correctly.
- Late sync: five data cycles with nDSYNC high → phase_err_o pulses once on the first extra cycle, next nDSYNC low gives no valid pulse; the following pixel is valid.
- Deblur: ndo_deblur 0, n64_480i 0, vmode 0, nCSYNC rising edge, then alternating pixels A, B, C, D → colour output updates only on the blank-enabled alternate pixels while vdata_valid_o pulses every pixel; with ndo_deblur 1 every pixel updates.
- Reset mid-pixel after two colour words: all outputs return to reset values; first post-reset nDSYNC low gives no valid pulse and no error; valid output appears one pixel later.
